// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit common-anode 7-segment scan scheduler.
// Double-buffered frames, dead-time blanking, per-digit enable, 16-level duty.
module display_scan_ctrl #(
   parameter int STEP_CYCLES = 780,
   parameter int BLANK_STEPS = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] frame_data,
   input  logic        frame_valid,
   output logic        frame_ready,
   input  logic [3:0]  digit_en,
   input  logic [3:0]  brightness,
   output logic [7:0]  segmentos,
   output logic [3:0]  sel_seg,
   output logic        frame_done
);

   localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
   localparam logic [4:0] BLANK_LAST = 5'(BLANK_STEPS - 1);
   localparam logic [4:0] LIT_LAST = 5'd15;

   typedef enum logic [1:0] {
      S_BLANK,
      S_LIT,
      S_DARK
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [SW-1:0] step_q;
   logic [4:0]    sub_q;
   logic [4:0]    sub_d;
   logic [1:0]    digit_q;
   logic [1:0]    digit_d;
   logic [3:0]    bright_q;
   logic [3:0]    en_q;
   logic [31:0]   active_q;
   logic [31:0]   shadow_q;
   logic          shadow_full;
   logic          step_tick;
   logic          slot_end;
   logic          boundary;
   logic          accept;
   logic          blank_first;
   logic [7:0]    digit_code;
   logic [7:0]    seg_d;
   logic [3:0]    sel_d;

   assign step_tick   = (step_q == STEP_LAST);
   assign boundary    = slot_end && (digit_q == 2'd3);
   assign accept      = frame_valid && !shadow_full;
   assign frame_ready = !shadow_full;
   assign blank_first = (state_q == S_BLANK) && (sub_q == 5'd0)
                        && (step_q == '0);

   // Free-running step prescaler; one step_tick every STEP_CYCLES clocks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step_q <= '0;
      end else if (step_tick) begin
         step_q <= '0;
      end else begin
         step_q <= step_q + SW'(1);
      end
   end

   // Per-slot FSM next state: BLANK -> LIT -> (DARK) -> next slot's BLANK.
   always_comb begin
      state_d  = state_q;
      sub_d    = sub_q;
      digit_d  = digit_q;
      slot_end = 1'b0;
      if (step_tick) begin
         unique case (state_q)
            S_BLANK: begin
               if (sub_q == BLANK_LAST) begin
                  state_d = S_LIT;
                  sub_d   = 5'd0;
               end else begin
                  sub_d = sub_q + 5'd1;
               end
            end
            S_LIT: begin
               if (sub_q == LIT_LAST) begin
                  slot_end = 1'b1;
               end else begin
                  sub_d = sub_q + 5'd1;
                  if (sub_q[3:0] == bright_q) begin
                     state_d = S_DARK;
                  end
               end
            end
            S_DARK: begin
               if (sub_q == LIT_LAST) begin
                  slot_end = 1'b1;
               end else begin
                  sub_d = sub_q + 5'd1;
               end
            end
            default: begin
               state_d = S_BLANK;
               sub_d   = 5'd0;
            end
         endcase
         if (slot_end) begin
            state_d = S_BLANK;
            sub_d   = 5'd0;
            digit_d = digit_q + 2'd1;
         end
      end
   end

   // FSM state, sub-step and digit registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_BLANK;
         sub_q   <= 5'd0;
         digit_q <= 2'd0;
      end else begin
         state_q <= state_d;
         sub_q   <= sub_d;
         digit_q <= digit_d;
      end
   end

   // Slot parameters latched on the first BLANK cycle, held for the slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bright_q <= 4'd0;
         en_q     <= 4'd0;
      end else if (blank_first) begin
         bright_q <= brightness;
         en_q     <= digit_en;
      end
   end

   // Shadow fills on accept; moves to active at the frame boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_q    <= '1;
         shadow_q    <= '1;
         shadow_full <= 1'b0;
      end else if (boundary && shadow_full) begin
         active_q    <= shadow_q;
         shadow_full <= 1'b0;
      end else if (accept) begin
         shadow_q    <= frame_data;
         shadow_full <= 1'b1;
      end
   end

   // Segment code for the digit the FSM is about to show.
   always_comb begin
      digit_code = 8'hFF;
      unique case (digit_d)
         2'd0: digit_code = active_q[7:0];
         2'd1: digit_code = active_q[15:8];
         2'd2: digit_code = active_q[23:16];
         2'd3: digit_code = active_q[31:24];
         default: digit_code = 8'hFF;
      endcase
   end

   // Drive values derived from next state so outputs track the FSM edge.
   always_comb begin
      seg_d = 8'hFF;
      sel_d = 4'hF;
      if ((state_d == S_LIT) && en_q[digit_d]) begin
         seg_d = digit_code;
         sel_d = ~(4'b0001 << digit_d);
      end
   end

   // Registered display drive and frame boundary pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         segmentos  <= 8'hFF;
         sel_seg    <= 4'hF;
         frame_done <= 1'b0;
      end else begin
         segmentos  <= seg_d;
         sel_seg    <= sel_d;
         frame_done <= boundary;
      end
   end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing scheduler for the 4-digit common-anode 7-segment display. It takes complete 4-digit frames of pre-encoded segment codes from the counter/encoder datapath through a valid/ready handshake and double-buffers them. It scans the digits with dead-time blanking and per-digit enable, and applies a 16-level brightness duty. It owns `segmentos`/`sel_seg` at the top level and replaces the free-running select counter and combinational mux.

## Interface
- `STEP_CYCLES`, default 780: clocks per step (≥2); step_tick fires when step counter = STEP_CYCLES-1.
- `BLANK_STEPS`, default 1: dead-time steps at the start of each digit slot (≥1).
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  asynchronous, active-low reset.
- `frame_data`  in  32  segment codes, active-low, bit 7 = dp.
  - [7:0] → digit 0 (sel 4'b1110), [15:8] → digit 1 (4'b1101), [23:16] → digit 2 (4'b1011), [31:24] → digit 3 (4'b0111).
- `frame_valid`  in  1  producer offers frame_data.
- `frame_ready`  out  1  shadow buffer empty; transfer on valid & ready at a rising edge.
- `digit_en`  in  4  per-digit enable; bit n gates digit n.
- `brightness`  in  4  lit steps per slot = brightness+1 (0 → 1/16, 15 → 16/16).
- `segmentos`  out  8  registered segment drive, active-low.
- `sel_seg`  out  4  registered digit select, active-low, at most one bit low.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.

## Operation
- **Buffers**
  - Active buffer (32 b) drives the display.
  - Shadow buffer (32 b) plus a `shadow_full` flag.
  - `frame_ready = ~shadow_full`.
  - Accept writes the shadow and sets `shadow_full`.
- **Slot and frame structure**
  - Slot = BLANK_STEPS + 16 steps.
  - Frame = slots for digits 0,1,2,3 in fixed order.
  - Disabled digits still consume their full slot, so refresh rate is independent of `digit_en`.
- **Per-slot FSM**
  - BLANK: for BLANK_STEPS steps, sel_seg=4'b1111, segmentos=8'hFF. Then go to LIT.
  - LIT: for steps 0..brightness_q, sel_seg=~(4'b0001<<digit) and segmentos=active[digit]. This applies only if digit_en_q[digit]=1; otherwise the outputs are the blank values. Then go to DARK, or go directly to the next slot's BLANK if brightness_q=15.
  - DARK: blank values until lit-window step 15 ends, then go to the next slot's BLANK.
- **Per-slot sampling**: `brightness` and `digit_en` are registered (brightness_q, digit_en_q) on the first cycle of each BLANK. Changes mid-slot take effect at the next slot.
- **Frame boundary** (the step_tick ending digit 3's lit window):
  - digit wraps 3→0 and `frame_done` pulses.
  - If `shadow_full`, active←shadow and `shadow_full` clears.
- **Simultaneous boundary and accept**:
  - With shadow empty, the accepted data goes to the shadow only; it swaps at the next boundary.
  - With shadow full, no accept is possible because ready=0.
- **Duty**: lit cycles per frame per enabled digit = (brightness+1)·STEP_CYCLES.

## Timing
- Reset (async assert, released synchronously to the first `clk` edge):
  - segmentos=8'hFF, sel_seg=4'b1111, frame_ready=1, frame_done=0.
  - Active buffer = all 8'hFF; shadow empty.
  - FSM in BLANK, digit 0, step counters 0.
- Reset asserted mid-frame returns to this state immediately. Any partially accepted or shadowed frame is discarded.
- Outputs are registered and change on the same edge as the FSM state. `segmentos` and `sel_seg` change together, with no intermediate glitch.
- Accept → `frame_ready` low on the next cycle.
- Swap happens on the boundary edge. `frame_ready` returns high and `frame_done`=1 for exactly that cycle.
- Swapped data appears on segmentos at the start of digit 0's LIT, i.e. BLANK_STEPS·STEP_CYCLES cycles after the boundary.
- Defaults: slot = 17·780 = 13260 cycles; frame = 53040 cycles (≈943 Hz at 50 MHz).
- Counters:
  - Step counter is $clog2(STEP_CYCLES) bits and wraps to 0.
  - Sub-step counter is 5 bits, covering BLANK_STEPS up to 16.
  - Digit index is 2 bits and wraps naturally.

## Test plan
- **Reset**: release rst → segmentos=8'hFF, sel_seg=4'b1111, frame_ready=1 until a frame is accepted; all-dark for the first full frame.
- **First load**: offer frame_data=32'hC0F9A4B0 (0,1,2,3 codes) with brightness=15 and digit_en=4'hF.
  - Ready drops on the next cycle.
  - After the next frame_done, digit 0 shows 8'hB0 with sel_seg=4'b1110 for exactly 16·STEP_CYCLES cycles, preceded by STEP_CYCLES blank cycles.
  - Then digit 1 shows 8'hA4 with sel 4'b1101.
- **Brightness**: brightness=0 → each digit's sel_seg is low for exactly STEP_CYCLES cycles per slot. Changing brightness mid-slot alters the duty from the following slot only.
- **Masking**: digit_en=4'b0101 → sel_seg never shows 4'b1101 or 4'b0111. Frame period stays 4·17·STEP_CYCLES.
- **Back-to-back frames**: hold frame_valid high with frames A, B, C.
  - A is accepted; B is accepted only after A's swap cycle (frame_done).
  - Never more than one pending frame; no frame lost or duplicated.
  - Valid arriving on the boundary cycle with shadow empty is displayed one frame later.
- **Reset mid-operation**: assert rst during digit 2's LIT with shadow full → outputs blank at once, frame_ready=1, and the old shadow is never displayed after release.
